// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, a one-entry redirect buffer for
// redirects that arrive while IF is stalled, the IF/DEC register and saturating counters.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2i_stall,
  input  logic                  i2d_stall,
  input  logic                  i2d_flush,
  input  logic                  load_pc_we,
  input  logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  output logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_rsp_valid,
  input  logic [31:0]           ic_rsp_data,
  output logic                  dec_valid,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [31:0]           dec_instr,
  output logic                  redirect_pending,
  output logic [CNT_WIDTH-1:0]  stat_fetched,
  output logic [CNT_WIDTH-1:0]  stat_miss_cycles,
  output logic [CNT_WIDTH-1:0]  stat_redirects
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] buf_reg, buf_next;
  logic [ADDR_WIDTH-1:0] eff_pc;

  logic                  dec_valid_reg;
  logic [ADDR_WIDTH-1:0] dec_pc_reg;
  logic [31:0]           dec_instr_reg;

  logic [2:0]            cnt_evt;
  logic [CNT_WIDTH-1:0]  cnt_reg [3];

  // Fetch address depends only on registered state, never on this cycle's redirect.
  assign eff_pc           = (state_reg == HOLD) ? buf_reg : pc_reg;
  assign ic_req_addr      = eff_pc;
  assign redirect_pending = (state_reg == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      buf_reg   <= buf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    buf_next   = buf_reg;
    case (state_reg)
      RUN: begin
        if (load_pc_we && !i2i_stall) begin
          pc_next = load_pc_new_pc;
        end else if (load_pc_we) begin
          buf_next   = load_pc_new_pc;
          state_next = HOLD;
        end else if (!i2i_stall) begin
          pc_next = pc_reg + PC_STEP;
        end
      end
      HOLD: begin
        if (load_pc_we) begin
          buf_next = load_pc_new_pc;
        end
        if (!i2i_stall) begin
          pc_next    = load_pc_we ? load_pc_new_pc : buf_reg;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // IF/DEC register: stall has priority over flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_valid_reg <= 1'b0;
      dec_pc_reg    <= '0;
      dec_instr_reg <= '0;
    end else if (!i2d_stall) begin
      dec_valid_reg <= i2d_flush ? 1'b0 : ic_rsp_valid;
      dec_pc_reg    <= eff_pc;
      dec_instr_reg <= ic_rsp_data;
    end
  end

  assign dec_valid = dec_valid_reg;
  assign dec_pc    = dec_pc_reg;
  assign dec_instr = dec_instr_reg;

  assign cnt_evt[0] = !i2d_stall && !i2d_flush && ic_rsp_valid;
  assign cnt_evt[1] = !ic_rsp_valid;
  assign cnt_evt[2] = load_pc_we;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_evt[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign stat_fetched     = cnt_reg[0];
  assign stat_miss_cycles = cnt_reg[1];
  assign stat_redirects   = cnt_reg[2];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default instance plus a 3-bit-counter,
// non-zero RESET_PC instance sharing the same stimulus.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2i_stall, i2d_stall, i2d_flush, load_pc_we;
  logic [31:0] load_pc_new_pc;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_data;

  logic [31:0] ic_req_addr, dec_pc, dec_instr;
  logic        dec_valid, redirect_pending;
  logic [31:0] stat_fetched, stat_miss_cycles, stat_redirects;

  logic [31:0] s_ic_req_addr, s_dec_pc, s_dec_instr;
  logic        s_dec_valid, s_redirect_pending;
  logic [2:0]  s_fetched, s_miss, s_redirects;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .i2i_stall(i2i_stall), .i2d_stall(i2d_stall),
    .i2d_flush(i2d_flush), .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc),
    .ic_req_addr(ic_req_addr), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
    .redirect_pending(redirect_pending), .stat_fetched(stat_fetched),
    .stat_miss_cycles(stat_miss_cycles), .stat_redirects(stat_redirects)
  );

  fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_1000), .CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .i2i_stall(i2i_stall), .i2d_stall(i2d_stall),
    .i2d_flush(i2d_flush), .load_pc_we(load_pc_we), .load_pc_new_pc(load_pc_new_pc),
    .ic_req_addr(s_ic_req_addr), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dec_valid(s_dec_valid), .dec_pc(s_dec_pc), .dec_instr(s_dec_instr),
    .redirect_pending(s_redirect_pending), .stat_fetched(s_fetched),
    .stat_miss_cycles(s_miss), .stat_redirects(s_redirects)
  );

  task automatic idle_inputs();
    i2i_stall = 0; i2d_stall = 0; i2d_flush = 0; load_pc_we = 0;
    load_pc_new_pc = '0; ic_rsp_valid = 0; ic_rsp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic test_reset();
    do_reset();
    ic_rsp_valid = 1; ic_rsp_data = 32'h1111_2222;
    step(); step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("reset_pending", {31'b0, redirect_pending}, 32'd0);
    chk("reset_addr", ic_req_addr, 32'h0);
    chk("reset_fetched", stat_fetched, 32'd0);
    chk("reset_miss", stat_miss_cycles, 32'd0);
    chk("reset_s_addr", s_ic_req_addr, 32'h0000_1000);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("first_edge_dec_pc", dec_pc, 32'h0);
    chk("first_edge_s_dec_pc", s_dec_pc, 32'h0000_1000);
    chk("first_edge_dec_valid", {31'b0, dec_valid}, 32'd1);
  endtask

  task automatic test_sequential();
    do_reset();
    ic_rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ic_rsp_data = 32'hA000_0000 + i;
      step();
      chk($sformatf("seq_dec_pc%0d", i), dec_pc, 32'(4 * i));
      chk($sformatf("seq_dec_instr%0d", i), dec_instr, 32'hA000_0000 + 32'(i));
      chk($sformatf("seq_dec_valid%0d", i), {31'b0, dec_valid}, 32'd1);
    end
    chk("seq_fetched", stat_fetched, 32'd4);
    chk("seq_miss", stat_miss_cycles, 32'd0);
  endtask

  task automatic test_redirect_stall();
    do_reset();
    ic_rsp_valid = 1;
    load_pc_we = 1; load_pc_new_pc = 32'h100; i2i_stall = 1;
    step();
    load_pc_we = 0; load_pc_new_pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("hold_pending%0d", i), {31'b0, redirect_pending}, 32'd1);
      chk($sformatf("hold_addr%0d", i), ic_req_addr, 32'h100);
      step();
    end
    chk("hold_pending2", {31'b0, redirect_pending}, 32'd1);
    i2i_stall = 0;
    step();
    chk("resume_pending", {31'b0, redirect_pending}, 32'd0);
    chk("resume_addr", ic_req_addr, 32'h100);
    step();
    chk("resume_next_addr", ic_req_addr, 32'h104);
    chk("resume_redirects", stat_redirects, 32'd1);
  endtask

  task automatic test_last_redirect_wins();
    do_reset();
    ic_rsp_valid = 1;
    load_pc_we = 1; load_pc_new_pc = 32'h100; i2i_stall = 1;
    step();
    load_pc_new_pc = 32'h200;
    step();
    chk("lrw_hold_addr", ic_req_addr, 32'h200);
    load_pc_we = 0; i2i_stall = 0;
    step();
    chk("lrw_resume_addr", ic_req_addr, 32'h200);
    chk("lrw_redirects", stat_redirects, 32'd2);
    load_pc_we = 1; load_pc_new_pc = 32'h300; i2i_stall = 1;
    step();
    load_pc_new_pc = 32'h400; i2i_stall = 0;
    step();
    chk("lrw_exit_with_we_addr", ic_req_addr, 32'h400);
    chk("lrw_exit_pending", {31'b0, redirect_pending}, 32'd0);
    load_pc_we = 0;
    step();
    chk("lrw_after_exit_addr", ic_req_addr, 32'h404);
    chk("lrw_redirects4", stat_redirects, 32'd4);
  endtask

  task automatic test_redirect_no_stall();
    do_reset();
    ic_rsp_valid = 1;
    step();
    load_pc_we = 1; load_pc_new_pc = 32'h0000_0800;
    step();
    load_pc_we = 0;
    chk("nostall_redirect_addr", ic_req_addr, 32'h800);
    chk("nostall_pending", {31'b0, redirect_pending}, 32'd0);
    chk("nostall_dec_pc", dec_pc, 32'h4);
  endtask

  task automatic test_stall_over_flush();
    do_reset();
    ic_rsp_valid = 1; ic_rsp_data = 32'hDEAD_BEEF;
    step();
    i2d_stall = 1; i2d_flush = 1; ic_rsp_data = 32'h1234_5678;
    step();
    chk("sof_hold_valid", {31'b0, dec_valid}, 32'd1);
    chk("sof_hold_pc", dec_pc, 32'h0);
    chk("sof_hold_instr", dec_instr, 32'hDEAD_BEEF);
    chk("sof_hold_fetched", stat_fetched, 32'd1);
    i2d_stall = 0;
    step();
    chk("sof_flush_valid", {31'b0, dec_valid}, 32'd0);
    chk("sof_flush_fetched", stat_fetched, 32'd1);
    i2d_flush = 0;
    step();
    chk("sof_reload_valid", {31'b0, dec_valid}, 32'd1);
    chk("sof_reload_pc", dec_pc, 32'hC);
    chk("sof_reload_instr", dec_instr, 32'h1234_5678);
  endtask

  task automatic test_miss_saturation();
    do_reset();
    ic_rsp_valid = 0; i2i_stall = 1;
    for (int i = 0; i < 5; i++) step();
    chk("miss_addr_held", ic_req_addr, 32'h0);
    chk("miss_count", stat_miss_cycles, 32'd5);
    chk("miss_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("miss_s_count", {29'b0, s_miss}, 32'd5);
    step(); step();
    chk("miss_s_full", {29'b0, s_miss}, 32'd7);
    step();
    chk("miss_s_saturated", {29'b0, s_miss}, 32'd7);
    chk("miss_count8", stat_miss_cycles, 32'd8);
    chk("miss_s_fetched", {29'b0, s_fetched}, 32'd0);
  endtask

  task automatic test_wrap_and_reset_hold();
    do_reset();
    ic_rsp_valid = 1;
    load_pc_we = 1; load_pc_new_pc = 32'hFFFF_FFFC;
    step();
    load_pc_we = 0;
    chk("wrap_top_addr", ic_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero_addr", ic_req_addr, 32'h0);
    load_pc_we = 1; load_pc_new_pc = 32'h300; i2i_stall = 1;
    step();
    load_pc_we = 0;
    chk("rsthold_pending_before", {31'b0, redirect_pending}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rsthold_pending", {31'b0, redirect_pending}, 32'd0);
    chk("rsthold_addr", ic_req_addr, 32'h0);
    chk("rsthold_redirects", stat_redirects, 32'd0);
    @(negedge clk);
    rst = 1'b0; i2i_stall = 0;
    step();
    chk("rsthold_after_addr", ic_req_addr, 32'h4);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_sequential();
    test_redirect_stall();
    test_last_redirect_wins();
    test_redirect_no_stall();
    test_stall_over_flush();
    test_miss_saturation();
    test_wrap_and_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
